// File: rtl/pixel_write_port.sv
// Pixel write port: range-checks pixel requests, queues them in a small FIFO
// and streams linear framebuffer writes through a one-entry output register.
module pixel_write_port #(
    parameter int X_BITS    = 11,
    parameter int Y_BITS    = 11,
    parameter int WIDTH     = 640,
    parameter int HEIGHT    = 480,
    parameter int DEPTH     = 4,
    parameter int ADDR_BITS = 19
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [X_BITS-1:0]    in_x,
    input  logic [Y_BITS-1:0]    in_y,
    input  logic                 in_color,
    output logic                 fb_we,
    output logic [ADDR_BITS-1:0] fb_addr,
    output logic                 fb_data,
    input  logic                 fb_stall,
    output logic [15:0]          drop_count,
    output logic                 idle
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [31:0] W_U = WIDTH;
    localparam logic [31:0] H_U = HEIGHT;

    typedef struct packed {
        logic [ADDR_BITS-1:0] addr;
        logic                 color;
    } pix_t;

    pix_t          mem_q [DEPTH];
    pix_t          mem_d [DEPTH];
    logic [PW-1:0] rd_q, rd_d;
    logic [PW-1:0] wr_q, wr_d;
    logic [CW-1:0] count_q, count_d;
    pix_t          out_q, out_d;
    logic          out_valid_q, out_valid_d;
    logic [15:0]   drop_q, drop_d;
    logic          ready_q;

    logic fifo_full;
    logic fifo_empty;
    logic accept;
    logic in_range;
    logic complete;
    logic load_slot;
    logic pop;
    logic bypass;
    logic push;
    pix_t entry;

    assign fifo_full  = (count_q == CW'(DEPTH));
    assign fifo_empty = (count_q == '0);

    // ready_q keeps in_ready low in reset and rises on the first edge after it
    assign in_ready = ready_q & ~fifo_full;
    assign accept   = in_valid & in_ready;
    assign in_range = (32'(in_x) < W_U) && (32'(in_y) < H_U);

    assign entry.addr  = ADDR_BITS'(in_y) * ADDR_BITS'(W_U) + ADDR_BITS'(in_x);
    assign entry.color = in_color;

    assign complete  = out_valid_q & ~fb_stall;
    assign load_slot = ~out_valid_q | complete;
    assign pop       = load_slot & ~fifo_empty;
    assign bypass    = load_slot & fifo_empty & accept & in_range;
    assign push      = accept & in_range & ~bypass;

    assign fb_we      = out_valid_q;
    assign fb_addr    = out_q.addr;
    assign fb_data    = out_q.color;
    assign drop_count = drop_q;
    assign idle       = fifo_empty & ~out_valid_q;

    // Next state: FIFO push/pop, output register load/bypass, drop counter
    always_comb begin
        mem_d       = mem_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        count_d     = count_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        drop_d      = drop_q;

        if (pop) begin
            out_d       = mem_q[rd_q];
            out_valid_d = 1'b1;
            rd_d        = rd_q + 1'b1;
        end else if (bypass) begin
            out_d       = entry;
            out_valid_d = 1'b1;
        end else if (complete) begin
            out_valid_d = 1'b0;
        end

        if (push) begin
            mem_d[wr_q] = entry;
            wr_d        = wr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (accept && !in_range && drop_q != 16'hFFFF) begin
            drop_d = drop_q + 16'd1;
        end
    end

    // State registers, cleared asynchronously by the active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_q        <= '0;
            wr_q        <= '0;
            count_q     <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            drop_q      <= '0;
            ready_q     <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            count_q     <= count_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            drop_q      <= drop_d;
            ready_q     <= 1'b1;
        end
    end

endmodule
